// File: rtl/gate_sequencer.sv
// gate_sequencer: measurement-window controller for the lab event counter.
//
// Opens a counting gate that is aligned to the 1 ms tick and lasts N_SHORT or
// N_LONG ms (chosen by Tmod when the gate opens). Event strobes inside the gate
// are counted with saturation. The total is published with a one-cycle valid
// pulse and then held for HOLD_MS ms. After that the block re-arms (cont=1) or
// returns to idle (cont=0).
//
// Ports:
//   clk, rst_n  - rising-edge clock, asynchronous active-low reset
//   ce_ms       - 1 ms tick, one clk wide
//   start       - level, starts a measurement from IDLE
//   cont        - level, re-arm after HOLD when 1
//   abort       - synchronous, forces IDLE from any state
//   Tmod        - 1: N_SHORT gate, 0: N_LONG gate (sampled at gate open)
//   ev          - single-cycle event strobe
//   gate        - high while the gate is open
//   busy        - high in every state except IDLE
//   count, ovf  - latched event total and saturation flag
//   valid       - one-cycle pulse when count/ovf update
//
// Handshake: there is no back-pressure. valid is a strobe; count/ovf are
// stable from the valid cycle until the next valid.
module gate_sequencer #(
    parameter int N_SHORT = 15,
    parameter int N_LONG  = 1000,
    parameter int HOLD_MS = 500,
    parameter int CW      = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ce_ms,
    input  logic          start,
    input  logic          cont,
    input  logic          abort,
    input  logic          Tmod,
    input  logic          ev,
    output logic          gate,
    output logic          busy,
    output logic [CW-1:0] count,
    output logic          ovf,
    output logic          valid
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALIGN,
        S_GATE,
        S_LATCH,
        S_HOLD
    } state_t;

    localparam logic [9:0] SHORT_LEN = 10'(N_SHORT);
    localparam logic [9:0] LONG_LEN  = 10'(N_LONG);
    localparam logic [9:0] HOLD_LAST = 10'(HOLD_MS - 1);

    state_t        state_q, state_d;
    logic [9:0]    ms_cnt_q, ms_cnt_d;
    logic [9:0]    len_q, len_d;
    logic [CW-1:0] ev_cnt_q, ev_cnt_d;
    logic          sat_q, sat_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          valid_q, valid_d;
    logic          gate_q, gate_d;
    logic          busy_q, busy_d;

    always_comb begin
        state_d  = state_q;
        ms_cnt_d = ms_cnt_q;
        len_d    = len_q;
        ev_cnt_d = ev_cnt_q;
        sat_d    = sat_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        valid_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_ALIGN;
            end
            S_ALIGN: begin
                if (ce_ms) begin
                    state_d  = S_GATE;
                    ms_cnt_d = '0;
                    ev_cnt_d = '0;
                    sat_d    = 1'b0;
                    len_d    = Tmod ? SHORT_LEN : LONG_LEN;
                end
            end
            S_GATE: begin
                // Saturating counter: an event arriving at all-ones flags overflow.
                if (ev) begin
                    if (&ev_cnt_q) sat_d = 1'b1;
                    else           ev_cnt_d = ev_cnt_q + 1'b1;
                end
                if (ce_ms) begin
                    ms_cnt_d = ms_cnt_q + 10'd1;
                    if (ms_cnt_q == len_q - 10'd1) state_d = S_LATCH;
                end
            end
            S_LATCH: begin
                count_d  = ev_cnt_q;
                ovf_d    = sat_q;
                valid_d  = 1'b1;
                ms_cnt_d = '0;
                state_d  = S_HOLD;
            end
            S_HOLD: begin
                if (ce_ms) begin
                    ms_cnt_d = ms_cnt_q + 10'd1;
                    if (ms_cnt_q == HOLD_LAST) state_d = cont ? S_ALIGN : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort wins over everything, including a result being latched this cycle.
        if (abort) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            count_d = count_q;
            ovf_d   = ovf_q;
        end

        // gate/busy are registered copies of the next-state decode so they
        // change on the same edge as the state register.
        gate_d = (state_d == S_GATE);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            ms_cnt_q <= '0;
            len_q    <= '0;
            ev_cnt_q <= '0;
            sat_q    <= 1'b0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            valid_q  <= 1'b0;
            gate_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ms_cnt_q <= ms_cnt_d;
            len_q    <= len_d;
            ev_cnt_q <= ev_cnt_d;
            sat_q    <= sat_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            valid_q  <= valid_d;
            gate_q   <= gate_d;
            busy_q   <= busy_d;
        end
    end

    assign gate  = gate_q;
    assign busy  = busy_q;
    assign count = count_q;
    assign ovf   = ovf_q;
    assign valid = valid_q;

endmodule

// File: doc/gate_sequencer.md
# gate_sequencer

Measurement-window controller for the lab frequency/event counter. It runs from the shared 1 ms clock-enable tick and opens a counting gate that is either N_SHORT ms or N_LONG ms long, selected by Tmod. It counts single-cycle event strobes inside the gate, publishes the latched result with a one-cycle valid pulse, holds the result for a display interval, and then re-arms (continuous mode) or stops (single-shot mode).

## Interface
- N_SHORT, 15: gate length in ms when Tmod=1; legal range 1..1023.
- N_LONG, 1000: gate length in ms when Tmod=0; legal range 1..1023.
- HOLD_MS, 500: hold (display) interval in ms after each result; legal range 1..1023.
- CW, 16: width of the event counter and result.
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ce_ms  in  1  1 ms tick; a one-clk-cycle pulse synchronous to clk.
- start  in  1  level; starts a measurement when the block is in IDLE.
- cont  in  1  level; 1 = re-arm after HOLD, 0 = go to IDLE after HOLD.
- abort  in  1  synchronous; forces IDLE from any state.
- Tmod  in  1  1 = N_SHORT gate, 0 = N_LONG gate; sampled only when a gate opens.
- ev  in  1  event strobe; one clk cycle, synchronous.
- gate  out  1  high while a gate is open.
- busy  out  1  high in every state except IDLE.
- count  out  CW  latched event total.
- ovf  out  1  set if the event counter saturated during the last gate.
- valid  out  1  one-cycle pulse when count/ovf update.

## Operation
- States: IDLE, ALIGN, GATE, LATCH, HOLD. The state register and all outputs are registered.
- IDLE: if start=1 and abort=0, go to ALIGN.
- ALIGN: waits for ce_ms so that the gate opens on a ms boundary.
  - On ce_ms: go to GATE.
  - In the same edge: ms_cnt←0, ev_cnt←0, sat←0, and the gate length is captured as len←(Tmod ? N_SHORT : N_LONG).
- GATE: gate=1.
  - Each ev=1 cycle increments ev_cnt. At all-ones, ev_cnt holds and sat←1.
  - Each ce_ms increments ms_cnt (10 bits).
  - On ce_ms with ms_cnt==len-1: go to LATCH. An ev in that same cycle is counted.
- LATCH: one cycle.
  - count←ev_cnt, ovf←sat, valid←1 at the edge ending LATCH. valid is high for exactly the following cycle.
  - ms_cnt←0. Go to HOLD.
  - ev is ignored in LATCH, HOLD, ALIGN and IDLE.
- HOLD: each ce_ms increments ms_cnt.
  - On ce_ms with ms_cnt==HOLD_MS-1: go to ALIGN if cont=1, else IDLE.
  - cont is sampled only at that transition.
- abort=1 in any state: go to IDLE on the next edge.
  - gate drops; no valid is produced; count and ovf keep their previous values.
  - abort has priority over start and over every other transition.
- A Tmod change during GATE has no effect until the next ALIGN→GATE transition.
- start held high in continuous mode is harmless. It is ignored outside IDLE.

## Timing
- Reset values: state=IDLE, gate=0, busy=0, count=0, ovf=0, valid=0, internal counters 0.
- busy rises 1 clk after start is sampled in IDLE.
- gate rises 1 clk after the ALIGN ce_ms. It falls 1 clk after the terminal ce_ms.
- The gate spans exactly len ce_ms ticks, the terminal tick included.
- valid and the new count appear 2 clk after the terminal ce_ms (1 clk after gate falls).
- The next gate cannot open before HOLD_MS ms plus one ALIGN tick have passed.
- Minimum spacing assumption: ce_ms period ≥ 3 clk. Behaviour with ce_ms held high continuously is undefined.
- Reset asserted mid-gate clears everything immediately. After rst_n rises, the block stays in IDLE until start.

## Test plan
Common setup: N_SHORT=4, N_LONG=8, HOLD_MS=2, CW=4, ce_ms every 10 clk.
- Single shot: Tmod=1, cont=0, start pulse, 7 ev inside the gate -> gate high for 4 ticks; count=7, ovf=0, one valid pulse; IDLE 2 ticks later, busy=0.
- Continuous: Tmod=0, cont=1, 3 then 5 events -> two gates of 8 ticks each, each separated by HOLD plus ALIGN; valid pulses with count=3, then count=5.
- Saturation: 20 ev in one gate -> count=15, ovf=1. The next gate with 2 ev -> count=2, ovf=0.
- Boundary events: ev coincident with the terminal ce_ms is counted; ev in the LATCH and ALIGN cycles is not counted. 1+1+1 such events -> count=1.
- Abort mid-gate after 3 ev, then restart with 2 ev -> no valid on the abort and count stays at its prior value; the restart yields count=2.
- Tmod toggled mid-gate and rst_n pulsed during HOLD -> the current gate keeps its length; after reset all outputs are 0 and the state is IDLE.
